// File: rtl/divider_param.sv
// Sequential restoring divider, signed or unsigned, one quotient bit per cycle.
// Define DIVIDER_ALIGN_EN to skip leading zeros of the dividend (data-dependent latency).
module divider_param #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow,
    output logic [2:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
`ifdef DIVIDER_ALIGN_EN
        S_ALIGN = 3'd2,
`endif
        S_ITER  = 3'd3,
        S_FIX   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_out_q, ovf_out_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted, diff;
    logic             ge;
    logic [WIDTH-1:0] q_fix, r_fix;

    always_comb begin
        a_neg   = sgn_q & a_q[WIDTH-1];
        b_neg   = sgn_q & b_q[WIDTH-1];
        mag_a   = a_neg ? (~a_q + 1'b1) : a_q;
        mag_b   = b_neg ? (~b_q + 1'b1) : b_q;
        // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        diff    = shifted - {1'b0, dvs_q};
        q_fix   = qneg_q ? (~quo_q + 1'b1) : quo_q;
        r_fix   = rneg_q ? (~WIDTH'(rem_q) + 1'b1) : WIDTH'(rem_q);
    end

`ifdef DIVIDER_ALIGN_EN
    logic [CW-1:0] nbits;
    logic [CW-1:0] pre_shift;

    // Significant bits of |dividend|; a zero dividend still needs one step.
    always_comb begin
        nbits = CW'(1);
        for (int i = 0; i < WIDTH; i++) begin
            if (quo_q[i]) nbits = CW'(i + 1);
        end
        pre_shift = CW'(WIDTH) - nbits;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_INIT;
            S_INIT: begin
                if (b_q == '0) state_d = S_DONE;
`ifdef DIVIDER_ALIGN_EN
                else           state_d = S_ALIGN;
`else
                else           state_d = S_ITER;
`endif
            end
`ifdef DIVIDER_ALIGN_EN
            S_ALIGN: state_d = S_ITER;
`endif
            S_ITER: if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready       = (state_q == S_IDLE);
        done        = (state_q == S_DONE);
        dbg_state_o = state_q;
    end

    // Result registers load only on entry to DONE and hold until the next one.
    always_comb begin
        sgn_d       = sgn_q;
        a_d         = a_q;
        b_d         = b_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_out_d   = ovf_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sgn_d = is_signed;
                    a_d   = dividend;
                    b_d   = divisor;
                end
            end
            S_INIT: begin
                quo_d  = mag_a;
                dvs_d  = mag_b;
                rem_d  = '0;
                cnt_d  = CW'(WIDTH);
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
                ovf_d  = sgn_q && (a_q == MOST_NEG) && (&b_q);
                if (b_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = a_q;
                    dbz_d       = 1'b1;
                    ovf_out_d   = 1'b0;
                end
            end
`ifdef DIVIDER_ALIGN_EN
            S_ALIGN: begin
                quo_d = quo_q << pre_shift;
                cnt_d = nbits;
            end
`endif
            S_ITER: begin
                quo_d = {quo_q[WIDTH-2:0], ge};
                rem_d = ge ? diff : shifted;
                cnt_d = cnt_q - CW'(1);
            end
            S_FIX: begin
                quotient_d  = q_fix;
                remainder_d = r_fix;
                dbz_d       = 1'b0;
                ovf_out_d   = ovf_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            sgn_q       <= sgn_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_out_q;

endmodule

// File: tb/tb_divider_param.sv
// Bench for divider_param: directed and random divisions checked against a
// behavioural model through an expected-result queue.
module tb_divider_param;

    localparam int W       = 16;
    localparam int TIMEOUT = 100;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         div_by_zero;
    logic         overflow;
    logic [2:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Expected entry packs {quotient, remainder, div_by_zero, overflow}.
    logic [2*W+1:0] exp_q[$];
    int             lat_q[$];

    always #5 clk = ~clk;

    divider_param #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .div_by_zero(div_by_zero),
        .overflow   (overflow),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W+1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        dz = 1'b0;
        ov = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            if (a == MOST_NEG && b == '1) begin
                q  = MOST_NEG;
                r  = '0;
                ov = 1'b1;
            end else begin
                q = W'($signed(a) / $signed(b));
                r = W'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r, dz, ov};
    endfunction

    // Edges from the accepting edge (counted as edge 1) to the edge that raises done.
    function automatic int model_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIVIDER_ALIGN_EN
        logic [W-1:0] m;
        int           n;
        if (b == '0) return 2;
        m = (s && a[W-1]) ? (~a + 1'b1) : a;
        n = 1;
        for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
        return n + 4;
`else
        if (b == '0) return 2;
        return (s | ~s) ? W + 3 : W + 3;
`endif
    endfunction

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int inject);
        logic [2*W+1:0] exp;
        int             lat;
        int             edges;
        exp_q.push_back(model(s, a, b));
        lat_q.push_back(model_lat(s, a, b));
        @(negedge clk);
        check("ready_before_start", ready, 1'b1);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        is_signed = 1'($urandom_range(0, 1));
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        edges = 1;
        while (done !== 1'b1 && edges < TIMEOUT) begin
            if (inject != 0 && edges == inject) begin
                start    = 1'b1;
                dividend = 16'd7;
                divisor  = 16'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        lat = lat_q.pop_front();
        check("done_seen", done, 1'b1);
        check("latency", edges, lat);
        check("quotient", quotient, exp[2*W+1:W+2]);
        check("remainder", remainder, exp[W+1:2]);
        check("div_by_zero", div_by_zero, exp[1]);
        check("overflow", overflow, exp[0]);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);
        check("quotient_hold", quotient, exp[2*W+1:W+2]);
        check("remainder_hold", remainder, exp[W+1:2]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, ready, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_quotient"}, quotient, '0);
        check({tag, "_remainder"}, remainder, '0);
        check({tag, "_dbz"}, div_by_zero, 1'b0);
        check({tag, "_ovf"}, overflow, 1'b0);
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        run_op(1'b0, 16'd100, 16'd7, 0);
        run_op(1'b1, 16'hFFF9, 16'd2, 0);
        run_op(1'b1, 16'd7, 16'hFFFE, 0);
        run_op(1'b1, 16'h8000, 16'hFFFF, 0);
        run_op(1'b0, 16'h8000, 16'hFFFF, 0);
        run_op(1'b0, 16'd1234, 16'd0, 0);
        run_op(1'b1, 16'hFFF9, 16'd0, 0);
        run_op(1'b0, 16'd5, 16'd1, 0);
        run_op(1'b0, 16'd0, 16'd3, 0);
        run_op(1'b0, 16'hFFFF, 16'd1, 0);
        run_op(1'b1, 16'h8000, 16'd1, 0);
        run_op(1'b1, 16'h8000, 16'h8000, 0);

        // Start while busy is dropped, not queued
        run_op(1'b0, 16'd100, 16'd7, 3);
        expect_no_done("no_queued_start", 30);

        // Reset in the middle of an iteration
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 16'd100;
        divisor   = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        expect_no_done("no_done_after_reset", W + 10);
        run_op(1'b0, 16'd50, 16'd5, 0);

        // Random vectors
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = W'($urandom_range(0, 15));
                1:       b = W'($urandom_range(0, 255)) | (s ? MOST_NEG : '0);
                default: b = W'($urandom);
            endcase
            if ($urandom_range(0, 4) == 0) a = W'($urandom_range(0, 40));
            run_op(s, a, b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/divider_param.md
DIVIDER_PARAM -- requirements
Module: divider_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal range 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; accepted only on an edge where ready=1.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port dividend  input  WIDTH  numerator.
REQ-007 SHALL have port divisor  input  WIDTH  denominator.
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have port quotient  output  WIDTH  result quotient.
REQ-010 SHALL have port remainder  output  WIDTH  result remainder.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-012 SHALL have port div_by_zero  output  1  status, valid with done.
REQ-013 SHALL have port overflow  output  1  status, valid with done.

Function
REQ-014 SHALL implement FSM states IDLE, INIT, ALIGN, ITER, FIX, DONE.
- IDLE->INIT on accepted start.
- INIT->DONE if divisor==0.
- INIT->ALIGN otherwise, or INIT->ITER when alignment is compiled out.
- ALIGN->ITER.
- ITER->FIX when the iteration counter reaches 0.
- FIX->DONE.
- DONE->IDLE.
REQ-015 SHALL register is_signed, dividend and divisor on the accepting edge; input changes afterwards SHALL be ignored.
REQ-016 INIT SHALL store magnitudes of both operands plus the result sign (dividend sign XOR divisor sign) and the dividend sign; when is_signed=0 both signs are 0.
REQ-017 ITER SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first; the partial remainder register is WIDTH+1 bits, so no step can overflow.
REQ-018 FIX SHALL negate the quotient if the result sign is 1 and negate the remainder if the dividend sign is 1; quotient truncates toward zero and a nonzero remainder takes the dividend's sign.
REQ-019 Without alignment, ITER SHALL run exactly WIDTH cycles; done SHALL rise WIDTH+3 edges after the accepting edge.
REQ-020 divisor==0 SHALL give quotient all ones, remainder = raw dividend, and div_by_zero=1; done SHALL rise 2 edges after acceptance.
REQ-021 Signed dividend = most-negative and divisor = -1 SHALL give quotient = most-negative, remainder 0, overflow=1, with normal latency.
REQ-022 quotient, remainder, div_by_zero and overflow SHALL update only on the edge that raises done and SHALL hold until the next done.
REQ-023 start asserted while ready=0 SHALL be ignored, with no queuing.
REQ-024 done SHALL be high for exactly one cycle, and only in DONE.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, ready=1, and done, quotient, remainder, div_by_zero and overflow to 0, including mid-operation.
REQ-026 An operation interrupted by reset SHALL produce no done pulse; the first accepted start after rst_n rises SHALL behave normally.

Configuration
REQ-027 Macro DIVIDER_ALIGN_EN defined: ALIGN SHALL count significant bits n of |dividend| (n = 1 when the dividend is 0), pre-shift the dividend so only n ITER cycles run, and raise done n+4 edges after acceptance.
REQ-028 Macro DIVIDER_ALIGN_EN undefined: the ALIGN state and leading-zero logic SHALL be absent, and latency is fixed per REQ-019.
REQ-029 Results SHALL be bit-identical with or without DIVIDER_ALIGN_EN.

Verification
REQ-030 WIDTH=16, unsigned, 100/7 -> quotient=14, remainder=2, flags 0; done 19 edges after acceptance (macro undefined).
REQ-031 Signed -7/2 -> quotient=0xFFFD, remainder=0xFFFF; signed 7/-2 -> quotient=0xFFFD, remainder=0x0001.
REQ-032 Signed 0x8000/0xFFFF -> quotient=0x8000, remainder=0, overflow=1; same operands unsigned -> quotient=0, remainder=0x8000, overflow=0.
REQ-033 1234/0 -> quotient=0xFFFF, remainder=1234, div_by_zero=1; done 2 edges after acceptance.
REQ-034 A second start 3 cycles into 100/7 SHALL be ignored with results unchanged; rst_n pulsed low mid-ITER -> no done, outputs 0; next start 50/5 -> quotient=10, remainder=0.
REQ-035 With DIVIDER_ALIGN_EN, 5/1 -> quotient=5, remainder=0, done 7 edges after acceptance; 0/3 -> quotient=0, remainder=0, done 5 edges after acceptance.
